// File: rtl/ma_ctrl_pkg.sv
// rtl/ma_ctrl_pkg.sv - shared types, defaults and log2 clamp for the moving-average controller
package ma_ctrl_pkg;

    localparam int MA_MAX_LOG2_DEF     = 4;
    localparam int MA_DEFAULT_LOG2_DEF = 2;
    localparam int MA_LOG2_WIDTH_DEF   = 3;
    localparam int MA_CNT_WIDTH_DEF    = 5;
    localparam int MA_FLUSH_CYCLES_DEF = 2;
    localparam int MA_DATA_LATENCY_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } ma_state_t;

    // Oversized window requests are limited to the largest supported window, never rejected
    function automatic int clamp_log2(input int req_log2, input int max_log2);
        return (req_log2 > max_log2) ? max_log2 : req_log2;
    endfunction

endpackage

// File: rtl/ma_valid_delay.sv
// rtl/ma_valid_delay.sv - fixed-depth valid delay line with synchronous clear
module ma_valid_delay
#(
    parameter int DEPTH = 1
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sr;

    // Shift the strobe through DEPTH stages; reset or clear empties every stage
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/moving_average_ctrl.sv
// rtl/moving_average_ctrl.sv - moving-average sequencing controller; MA_CTRL_DROP_CNT_EN enables drop_count
module moving_average_ctrl
    import ma_ctrl_pkg::*;
#(
    parameter int MAX_LOG2     = MA_MAX_LOG2_DEF,
    parameter int DEFAULT_LOG2 = MA_DEFAULT_LOG2_DEF,
    parameter int LOG2_WIDTH   = MA_LOG2_WIDTH_DEF,
    parameter int CNT_WIDTH    = MA_CNT_WIDTH_DEF,
    parameter int FLUSH_CYCLES = MA_FLUSH_CYCLES_DEF,
    parameter int DATA_LATENCY = MA_DATA_LATENCY_DEF
)
(
    input  logic                  clk,
    input  logic                  rst_active_high,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [LOG2_WIDTH-1:0] cfg_log2,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ma_en,
    output logic                  ma_clear,
    output logic [LOG2_WIDTH-1:0] ma_log2,
    output logic                  avg_valid,
    output logic [CNT_WIDTH-1:0]  fill_count,
    output logic [1:0]            state,
    output logic [15:0]           drop_count
);

    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    ma_state_t             r_state;
    ma_state_t             w_state_nxt;
    logic [LOG2_WIDTH-1:0] r_log2;
    logic [LOG2_WIDTH-1:0] w_log2_nxt;
    logic [CNT_WIDTH-1:0]  r_fill;
    logic [CNT_WIDTH-1:0]  w_fill_nxt;
    logic [FLUSH_W-1:0]    r_flush_cnt;
    logic [FLUSH_W-1:0]    w_flush_nxt;
    logic                  w_dly_clr;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [LOG2_WIDTH-1:0] w_cfg_clamped;
    logic [CNT_WIDTH-1:0]  w_n;
    logic [CNT_WIDTH-1:0]  w_fill_inc;
    logic                  w_full_after;

    assign w_cfg_clamped = LOG2_WIDTH'(clamp_log2(int'(cfg_log2), MAX_LOG2));
    assign w_n           = CNT_WIDTH'(1) << r_log2;
    assign w_fill_inc    = r_fill + 1'b1;

    // A pending config request takes the cycle, so data is held off while cfg_valid is high
    assign w_in_ready = ((r_state == ST_FILL) || (r_state == ST_RUN)) && enable && !cfg_valid;
    assign w_accept   = in_valid && w_in_ready;

    // The window is full after this accept if we are already running or this is the N-th sample
    assign w_full_after = w_accept && ((r_state == ST_RUN) || (w_fill_inc == w_n));

    // Next-state, window and fill-count decisions
    always_comb begin
        w_state_nxt = r_state;
        w_log2_nxt  = r_log2;
        w_fill_nxt  = r_fill;
        w_flush_nxt = r_flush_cnt;
        w_dly_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_log2_nxt  = w_cfg_clamped;
                    w_state_nxt = ST_FLUSH;
                end else if (enable) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt = ST_FILL;
                    w_flush_nxt = '0;
                    w_fill_nxt  = '0;
                end else begin
                    w_flush_nxt = r_flush_cnt + 1'b1;
                end
            end
            ST_FILL, ST_RUN: begin
                if (cfg_valid) begin
                    w_log2_nxt  = w_cfg_clamped;
                    w_state_nxt = ST_FLUSH;
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && (r_state == ST_FILL)) begin
                    w_fill_nxt = w_fill_inc;
                    if (w_fill_inc == w_n) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Every entry into FLUSH starts a fresh window and discards in-flight strobes
        if ((w_state_nxt == ST_FLUSH) && (r_state != ST_FLUSH)) begin
            w_dly_clr   = 1'b1;
            w_flush_nxt = '0;
            w_fill_nxt  = '0;
        end
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst_active_high) begin
            r_state     <= ST_IDLE;
            r_log2      <= LOG2_WIDTH'(DEFAULT_LOG2);
            r_fill      <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_log2      <= w_log2_nxt;
            r_fill      <= w_fill_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    ma_valid_delay #(
        .DEPTH (DATA_LATENCY)
    ) u_valid_delay (
        .i_clk (clk),
        .i_rst (rst_active_high),
        .i_clr (w_dly_clr),
        .i_d   (w_full_after),
        .o_q   (avg_valid)
    );

    assign cfg_ready  = (r_state != ST_FLUSH);
    assign in_ready   = w_in_ready;
    assign ma_en      = w_accept;
    assign ma_clear   = (r_state == ST_FLUSH);
    assign ma_log2    = r_log2;
    assign fill_count = r_fill;
    assign state      = r_state;

`ifdef MA_CTRL_DROP_CNT_EN
    logic [15:0] r_drop;

    // Count samples the stream offered while we could not take them, saturating
    always_ff @(posedge clk) begin
        if (rst_active_high) begin
            r_drop <= '0;
        end else if (in_valid && !w_in_ready && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    assign drop_count = r_drop;
`else
    assign drop_count = '0;
`endif

endmodule

// File: doc/moving_average_ctrl.md
Name: moving_average_ctrl

Overview:
Sequencing controller for the moving-average datapath. It owns the active window length, clears the datapath when the window changes, and gates the input stream. It tracks warm-up so the average is marked valid only once the window holds N real samples. It sits between the ADC sample stream and the moving-average datapath, with a config port driven by the register bank.

Parameters:
MAX_LOG2, 4, log2 of the largest supported window (max N = 16)
DEFAULT_LOG2, 2, window log2 loaded at reset (N = 4)
LOG2_WIDTH, 3, width of window-log2 fields
CNT_WIDTH, 5, fill counter width (MAX_LOG2+1)
FLUSH_CYCLES, 2, cycles ma_clear is held per flush (at least 1)
DATA_LATENCY, 1, cycles from datapath enable to updated average_out (at least 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_active_high  in  1  synchronous, active-high reset
enable  in  1  run request from register bank
cfg_valid  in  1  new window request
cfg_ready  out  1  config handshake ready
cfg_log2  in  LOG2_WIDTH  requested window log2
in_valid  in  1  sample present on stream
in_ready  out  1  controller accepts sample
ma_en  out  1  datapath shift/accumulate enable (= in_valid & in_ready)
ma_clear  out  1  datapath synchronous clear of taps and sum
ma_log2  out  LOG2_WIDTH  active window log2; datapath shift amount
avg_valid  out  1  strobe: average_out reflects a full window
fill_count  out  CNT_WIDTH  samples accepted since last flush, saturates at 2^ma_log2
state  out  2  IDLE=0, FLUSH=1, FILL=2, RUN=3
drop_count  out  16  dropped-sample counter (optional feature)

Behaviour:
- Only clk and rst_active_high are fixed: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ma_log2=DEFAULT_LOG2, fill_count=0, flush counter=0, ma_clear=0, avg_valid=0 with the delay line cleared, drop_count=0.
- Reset mid-operation returns to IDLE next edge. There is no clear pulse, and pending avg_valid strobes are discarded.
- Outputs by state (registered unless noted):
  - cfg_ready = 1 in IDLE/FILL/RUN, 0 in FLUSH.
  - in_ready (combinational) = (state is FILL or RUN) & enable & ~cfg_valid. Config wins over data in the same cycle.
  - ma_clear = 1 exactly while state=FLUSH.
- IDLE:
  - cfg_valid: latch min(cfg_log2, MAX_LOG2) into ma_log2, go to FLUSH.
  - else enable=1: go to FLUSH with the current ma_log2.
- FLUSH: lasts exactly FLUSH_CYCLES cycles, then FILL with fill_count=0. The avg_valid delay line is cleared on entry.
- FILL:
  - Each accept increments fill_count.
  - The accept that makes fill_count = 2^ma_log2 moves to RUN next cycle.
  - ma_log2=0 (N=1) reaches RUN after one accept.
- RUN: fill_count holds at 2^ma_log2.
- FILL/RUN exits:
  - cfg_valid (handshake completes): latch clamped value, go to FLUSH.
  - else enable=0: go to IDLE; the delay line drains normally.
- avg_valid = a DATA_LATENCY-deep delay of (ma_en & window full after this accept). The first strobe comes DATA_LATENCY cycles after the N-th accept; in RUN it follows every accept.
- cfg_log2 > MAX_LOG2 is clamped, never rejected. A cfg equal to the current value still flushes.

Optional Feature:
MA_CTRL_DROP_CNT_EN
- Defined: drop_count increments, saturating at 16'hFFFF, on every cycle with in_valid=1 & in_ready=0 (the ADC stream cannot stall). It clears on reset only.
- Undefined: drop_count tied to 0; no counter logic.

Decomposition:
- Package ma_ctrl_pkg: state typedef (IDLE/FLUSH/FILL/RUN encodings), default parameter constants, clamp function for the log2 value.
- One sub-module: ma_valid_delay, a DATA_LATENCY-deep shift register with a synchronous clear, used for avg_valid.

Test Plan:
1. Reset, then enable=1, in_valid=1 constant, defaults:
   - FLUSH 2 cycles with ma_clear=1, then FILL.
   - 4 accepts, then RUN.
   - avg_valid first high 1 cycle after the 4th accept, then every cycle.
2. In RUN, cfg_valid=1 with cfg_log2=3:
   - in_ready=0 that cycle, cfg accepted.
   - FLUSH 2 cycles, ma_log2=3.
   - avg_valid only after 8 further accepts.
3. cfg_log2=7 -> ma_log2=4; 16 accepts before the first avg_valid; fill_count saturates at 16.
4. Window 4, in_valid alternating 1,0 in FILL:
   - accepts only on valid cycles.
   - RUN after the 4th accept (7th FILL cycle).
   - avg_valid one cycle later.
5. rst_active_high pulsed mid-FILL with fill_count=2:
   - next cycle state=IDLE, fill_count=0, ma_log2=2, avg_valid=0, ma_clear=0.
6. MA_CTRL_DROP_CNT_EN defined, in_valid=1 through IDLE (3 cycles) plus FLUSH (2 cycles) -> drop_count=5. Macro undefined -> drop_count=0.
